// File: rtl/shift_sequencer_pkg.sv
// Shared types for the shift sequencer: shift op codes and FSM states.
// Imported by the sequencer top and its single-bit shifter.
package shift_sequencer_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LEFT = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Ops that finish without any shift step.
  function automatic logic is_noop(
    input logic [1:0]    op,
    input logic [CW-1:0] amt
  );
    return (op == SH_NONE) || (amt == '0);
  endfunction

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Combinational single-bit shifter used by the shift sequencer.
// One step per call: left, logical right, arithmetic right or pass.
module shift_sequencer_shifter
  import shift_sequencer_pkg::*;
(
  input  logic [DW-1:0] data_i,
  input  logic [1:0]    shift_i,
  output logic [DW-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    unique case (shift_op_e'(shift_i))
      SH_NONE: data_o = data_i;
      SH_LEFT: data_o = {data_i[DW-2:0], 1'b0};
      SH_LSR:  data_o = {1'b0, data_i[DW-1:1]};
      SH_ASR:  data_o = {data_i[DW-1], data_i[DW-1:1]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one bit per clock for amt cycles, then a
// one-cycle done pulse; dout holds the result until the next start.
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [15:0]   din,
  input  logic [1:0]    op,
  input  logic [3:0]    amt,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [15:0]   dout
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] step;

  shift_sequencer_shifter u_shifter (
    .data_i  (dout_q),
    .shift_i (op_q),
    .data_o  (step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= SH_NONE;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dout_d  = dout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          dout_d = din;
          cnt_d  = amt;
          op_d   = op;
          if (is_noop(op, amt)) state_d = ST_DONE;
          else                  state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        dout_d = step;
        // cnt is at least 1 here, so the decrement cannot wrap.
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign done  = (state_q == ST_DONE);
  assign dout  = dout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, results, ignored
// restarts and asynchronous reset behaviour.
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] din;
  logic [1:0]  op;
  logic [3:0]  amt;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] dout;

  int n_chk;
  int n_pass;

  shift_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .din   (din),
    .op    (op),
    .amt   (amt),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Caller is at a negedge with the DUT idle. Optionally re-pulses
  // start with din=0 two cycles into the run.
  task automatic run(
    input  string       tag,
    input  logic [15:0] d,
    input  logic [1:0]  o,
    input  logic [3:0]  a,
    input  bit          repulse,
    input  int          exp_lat,
    input  logic [15:0] exp_dout
  );
    int lat;
    int bcyc;
    start = 1'b1; din = d; op = o; amt = a;
    @(negedge clk);
    start = 1'b0;
    din = 16'($urandom);
    op = 2'($urandom);
    amt = 4'($urandom);
    lat = 0;
    bcyc = 0;
    while (!done && lat < 40) begin
      if (busy) bcyc++;
      if (repulse && lat == 1) begin
        start = 1'b1; din = 16'h0000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (busy) bcyc++;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_dout"}, {16'd0, dout}, {16'd0, exp_dout});
    check({tag, "_busy"}, bcyc, exp_lat + 1);
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, ready, done}, 32'd2);
  endtask

  initial begin
    bit seen;
    n_chk = 0;
    n_pass = 0;
    start = 1'b0; din = '0; op = '0; amt = '0;
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dout", {16'd0, dout}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    run("left4", 16'h0001, 2'b01, 4'd4, 1'b0, 4, 16'h0010);
    run("asr15", 16'h8000, 2'b11, 4'd15, 1'b0, 15, 16'hFFFF);
    run("lsr15", 16'h8000, 2'b10, 4'd15, 1'b0, 15, 16'h0001);
    run("amt0", 16'h1234, 2'b01, 4'd0, 1'b0, 0, 16'h1234);
    run("opnone", 16'h1234, 2'b00, 4'd9, 1'b0, 0, 16'h1234);
    run("repulse", 16'hFFFF, 2'b01, 4'd8, 1'b1, 8, 16'hFF00);
    run("lsr4", 16'hF00F, 2'b10, 4'd4, 1'b0, 4, 16'h0F00);
    run("asr3", 16'h4008, 2'b11, 4'd3, 1'b0, 3, 16'h0801);
    run("left15", 16'h0003, 2'b01, 4'd15, 1'b0, 15, 16'h8000);

    repeat (3) @(negedge clk);
    check("idle_hold", {16'd0, dout}, 32'h8000);
    check("idle_ready", {31'd0, ready}, 32'd1);

    // Abort mid-run, just after edge T0+3.
    start = 1'b1; din = 16'h0003; op = 2'b01; amt = 4'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_dout", {16'd0, dout}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_nodone", {31'd0, seen}, 32'd0);
    reset = 1'b1;
    run("postrst", 16'h00F0, 2'b10, 4'd4, 1'b0, 4, 16'h000F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
